// File: rtl/anc_pkg.sv
// Shared types and constants for the ANC analysis chain.
// The framer and the Hanning stage agree on frame length and hop.
package anc_pkg;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 64;
    localparam int HOP       = 32;
    localparam int BUF_DEPTH = 2 * FRAME_LEN;

    // Q8.24 audio sample
    typedef logic signed [31:0] sample_t;

    typedef enum logic {
        FR_IDLE = 1'b0,
        FR_READ = 1'b1
    } fr_state_t;

endpackage

// File: rtl/overlap_framer_if.sv
// Sample stream into the framer and the framed burst out of it.
// The master side feeds samples; the slave side is the framer.
interface overlap_framer_if #(
    parameter int DATA_W = 32
) ();

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_first;
    logic              out_last;
    logic              overrun;

    modport master (
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  out_first,
        input  out_last,
        input  overrun
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output out_first,
        output out_last,
        output overrun
    );

endinterface

// File: rtl/framer_ram.sv
// Simple dual-port sample history: one write port, one registered read.
// A read and write to the same address in one cycle returns the old word.
module framer_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/overlap_framer.sv
// Overlapping frame replay: every HOP samples, the newest FRAME_LEN
// samples are streamed out oldest first as one contiguous burst.
module overlap_framer
    import anc_pkg::*;
#(
    parameter int DATA_W    = anc_pkg::DATA_W,
    parameter int FRAME_LEN = anc_pkg::FRAME_LEN,
    parameter int HOP       = anc_pkg::HOP,
    parameter int BUF_DEPTH = 2 * FRAME_LEN
) (
    input  logic             clk,
    input  logic             reset,
    overlap_framer_if.slave  bus
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int FW = $clog2(FRAME_LEN) + 1;
    localparam int HW = (HOP > 1) ? $clog2(HOP) : 1;

    fr_state_t         state_q;
    fr_state_t         state_d;

    logic [AW-1:0]     wr_ptr;
    logic [FW-1:0]     fill;
    logic [HW-1:0]     hop_cnt;

    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     rd_cnt;
    logic              pending;
    logic [AW-1:0]     pending_start;
    logic              overrun_q;

    logic              fill_hit;
    logic              fill_full;
    logic              hop_wrap;
    logic              trig;
    logic [AW-1:0]     frame_start;

    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_end;
    logic              load_now;
    logic [AW-1:0]     load_addr;

    logic [DATA_W-1:0] ram_q;
    logic              rd_vld_q;
    logic              rd_first_q;
    logic              rd_last_q;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_first_q;
    logic              out_last_q;

    // Trigger: first sample that fills the window, then every hop wrap.
    assign fill_hit    = (fill == FW'(FRAME_LEN - 1));
    assign fill_full   = (fill == FW'(FRAME_LEN));
    assign hop_wrap    = (hop_cnt == HW'(HOP - 1));
    assign trig        = bus.in_valid && (fill_hit || (fill_full && hop_wrap));
    assign frame_start = wr_ptr + AW'(BUF_DEPTH - FRAME_LEN + 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            fill    <= '0;
            hop_cnt <= '0;
        end else if (bus.in_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (!fill_full) begin
                fill <= fill + FW'(1);
            end
            hop_cnt <= hop_wrap ? '0 : hop_cnt + HW'(1);
        end
    end

    framer_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (bus.in_valid),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FR_IDLE: begin
                if (trig) begin
                    state_d = FR_READ;
                end
            end
            FR_READ: begin
                if (rd_end && !pending && !trig) begin
                    state_d = FR_IDLE;
                end
            end
            default: state_d = FR_IDLE;
        endcase
    end

    // At the end of a frame the pending slot drains before a new trigger
    // is considered, so a coincident trigger chains straight on.
    always_comb begin
        rd_en     = (state_q == FR_READ);
        rd_addr   = rd_ptr + AW'(rd_cnt);
        rd_end    = rd_en && (rd_cnt == CW'(FRAME_LEN - 1));
        load_now  = ((state_q == FR_IDLE) && trig) ||
                    (rd_end && (pending || trig));
        load_addr = (rd_end && pending) ? pending_start : frame_start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr        <= '0;
            rd_cnt        <= '0;
            pending       <= 1'b0;
            pending_start <= '0;
            overrun_q     <= 1'b0;
        end else begin
            if (load_now) begin
                rd_ptr <= load_addr;
                rd_cnt <= '0;
            end else if (rd_en) begin
                rd_cnt <= rd_cnt + CW'(1);
            end
            if (rd_end && pending) begin
                pending <= trig;
                if (trig) begin
                    pending_start <= frame_start;
                end
            end else if (rd_en && !rd_end && trig) begin
                if (pending) begin
                    overrun_q <= 1'b1;
                end else begin
                    pending       <= 1'b1;
                    pending_start <= frame_start;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q    <= 1'b0;
            rd_first_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            rd_vld_q    <= rd_en;
            rd_first_q  <= rd_en && (rd_cnt == '0);
            rd_last_q   <= rd_end;
            out_valid_q <= rd_vld_q;
            out_data_q  <= rd_vld_q ? ram_q : '0;
            out_first_q <= rd_first_q;
            out_last_q  <= rd_last_q;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign bus.overrun   = overrun_q;

endmodule
